// File: rtl/onchip_mem_master_if.sv
// Avalon-MM bus between the block-operation master and the on-chip memory slave port.
interface onchip_mem_master_if #(
    parameter int ADDR_W = 18
) ();
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [31:0]       m_writedata;
    logic [3:0]        m_byteenable;
    logic              m_waitrequest;
    logic [31:0]       m_readdata;
    logic              m_readdatavalid;

    modport master (
        output m_address, m_read, m_write, m_writedata, m_byteenable,
        input  m_waitrequest, m_readdata, m_readdatavalid
    );

    modport slave (
        input  m_address, m_read, m_write, m_writedata, m_byteenable,
        output m_waitrequest, m_readdata, m_readdatavalid
    );
endinterface

// File: rtl/onchip_mem_master.sv
// Command-driven Avalon-MM master: word copy, pattern fill and 32-bit additive checksum.
// state     | meaning
// S_IDLE    | cmd_ready high, waiting for a command
// S_RD_REQ  | m_read held until the slave drops m_waitrequest
// S_RD_WAIT | read accepted, waiting for m_readdatavalid
// S_WR_REQ  | m_write held until the slave drops m_waitrequest
// S_FINISH  | done pulse, result/error valid, back to idle
module onchip_mem_master #(
    parameter int ADDR_W = 18,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [31:0]       cmd_pattern,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       result,
    onchip_mem_master_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_FINISH} state_t;

    localparam logic [1:0] OP_COPY = 2'd0;
    localparam logic [1:0] OP_FILL = 2'd1;
    localparam logic [1:0] OP_CSUM = 2'd2;

    state_t            state, state_nxt;
    logic [1:0]        op_q, op_nxt;
    logic [ADDR_W-1:0] src_q, src_nxt, dst_q, dst_nxt;
    logic [LEN_W-1:0]  rem_q, rem_nxt;
    logic [31:0]       acc_q, acc_nxt;

    logic              accept, cmd_err, rd_xfer, wr_xfer, rd_data, last_word;

    logic              cmd_ready_nxt, busy_nxt, done_nxt, error_nxt;
    logic [31:0]       result_nxt;
    logic              m_read_q, m_read_nxt, m_write_q, m_write_nxt;
    logic [ADDR_W-1:0] m_address_q, m_address_nxt;
    logic [31:0]       m_writedata_q, m_writedata_nxt;

    assign accept    = (state == S_IDLE) && cmd_valid;
    assign rd_xfer   = (state == S_RD_REQ) && !bus.m_waitrequest;
    assign wr_xfer   = (state == S_WR_REQ) && !bus.m_waitrequest;
    assign rd_data   = (state == S_RD_WAIT) && bus.m_readdatavalid;
    assign last_word = (rem_q == LEN_W'(1));

    // Only the addresses an op actually uses are alignment-checked.
    always_comb begin
        cmd_err = 1'b0;
        case (cmd_op)
            OP_COPY: cmd_err = (|cmd_src[1:0]) | (|cmd_dst[1:0]);
            OP_FILL: cmd_err = |cmd_dst[1:0];
            OP_CSUM: cmd_err = |cmd_src[1:0];
            default: cmd_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_err || cmd_len == '0) state_nxt = S_FINISH;
                    else if (cmd_op == OP_FILL)   state_nxt = S_WR_REQ;
                    else                          state_nxt = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (rd_xfer) state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (rd_data) begin
                    if (op_q == OP_COPY) state_nxt = S_WR_REQ;
                    else if (last_word)  state_nxt = S_FINISH;
                    else                 state_nxt = S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                if (wr_xfer) begin
                    if (last_word)           state_nxt = S_FINISH;
                    else if (op_q == OP_FILL) state_nxt = S_WR_REQ;
                    else                     state_nxt = S_RD_REQ;
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so a request is visible the cycle after accept.
    always_comb begin
        op_nxt  = op_q;
        src_nxt = src_q;
        dst_nxt = dst_q;
        rem_nxt = rem_q;
        acc_nxt = acc_q;
        if (accept) begin
            op_nxt  = cmd_op;
            src_nxt = cmd_src;
            dst_nxt = cmd_dst;
            rem_nxt = cmd_len;
            acc_nxt = '0;
        end
        if (rd_xfer) src_nxt = src_q + ADDR_W'(4);
        if (wr_xfer) begin
            dst_nxt = dst_q + ADDR_W'(4);
            rem_nxt = rem_q - LEN_W'(1);
        end
        if (rd_data && op_q == OP_CSUM) begin
            acc_nxt = acc_q + bus.m_readdata;
            rem_nxt = rem_q - LEN_W'(1);
        end

        cmd_ready_nxt = (state_nxt == S_IDLE);
        busy_nxt      = (state_nxt != S_IDLE);
        done_nxt      = (state_nxt == S_FINISH);
        error_nxt     = accept && cmd_err;
        result_nxt    = result;
        if (state_nxt == S_FINISH)
            result_nxt = (state == S_RD_WAIT && op_q == OP_CSUM) ? acc_nxt : 32'd0;

        m_read_nxt    = (state_nxt == S_RD_REQ);
        m_write_nxt   = (state_nxt == S_WR_REQ);
        m_address_nxt = m_address_q;
        if (state_nxt == S_RD_REQ)      m_address_nxt = src_nxt;
        else if (state_nxt == S_WR_REQ) m_address_nxt = dst_nxt;

        m_writedata_nxt = m_writedata_q;
        if (state_nxt == S_WR_REQ) begin
            if (state == S_IDLE)         m_writedata_nxt = cmd_pattern;
            else if (state == S_RD_WAIT) m_writedata_nxt = bus.m_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q          <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            rem_q         <= '0;
            acc_q         <= '0;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            result        <= '0;
            m_read_q      <= 1'b0;
            m_write_q     <= 1'b0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
        end else begin
            op_q          <= op_nxt;
            src_q         <= src_nxt;
            dst_q         <= dst_nxt;
            rem_q         <= rem_nxt;
            acc_q         <= acc_nxt;
            cmd_ready     <= cmd_ready_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            error         <= error_nxt;
            result        <= result_nxt;
            m_read_q      <= m_read_nxt;
            m_write_q     <= m_write_nxt;
            m_address_q   <= m_address_nxt;
            m_writedata_q <= m_writedata_nxt;
        end
    end

    assign bus.m_read       = m_read_q;
    assign bus.m_write      = m_write_q;
    assign bus.m_address    = m_address_q;
    assign bus.m_writedata  = m_writedata_q;
    assign bus.m_byteenable = 4'hF;
endmodule

// File: tb/tb_onchip_mem_master.sv
// Directed bench for onchip_mem_master with a stall/latency-configurable memory model.
module tb_onchip_mem_master;
    localparam int ADDR_W = 18;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_dst;
    logic [LEN_W-1:0]  cmd_len;
    logic [31:0]       cmd_pattern;
    logic              busy;
    logic              done;
    logic              error;
    logic [31:0]       result;

    always #5 clk = ~clk;

    onchip_mem_master_if #(.ADDR_W(ADDR_W)) bus ();

    onchip_mem_master #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_pattern(cmd_pattern),
        .busy(busy), .done(done), .error(error), .result(result),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: stall_cfg wait cycles per request, rd_lat cycles read latency.
    int                cyc = 0;
    int                stall_cfg = 0;
    int                stall_left = 0;
    int                rd_lat = 1;
    int                rd_cnt = 0;
    logic [31:0]       rd_hold;
    logic [31:0]       mem [0:65535];
    logic              pl_en;
    logic [15:0]       pl_idx;
    logic [31:0]       pl_data;
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [31:0]       wr_data_q [$];
    int                wr_cyc_q  [$];
    int                rd_cyc_q  [$];
    int                req_cycles = 0;
    int                done_pulses = 0;
    int                rw_both = 0;
    int                unstable = 0;
    logic              stall_prev = 1'b0;
    logic              prev_rd, prev_wr;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_data;

    assign bus.m_waitrequest = (bus.m_read || bus.m_write) && (stall_left != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.m_readdatavalid <= 1'b0;
        if (pl_en) mem[pl_idx] <= pl_data;
        if (rd_cnt != 0) begin
            rd_cnt <= rd_cnt - 1;
            if (rd_cnt == 1) begin
                bus.m_readdatavalid <= 1'b1;
                bus.m_readdata      <= rd_hold;
            end
        end
        if (bus.m_read || bus.m_write) begin
            req_cycles <= req_cycles + 1;
            if (stall_left != 0) begin
                stall_left <= stall_left - 1;
            end else begin
                stall_left <= stall_cfg;
                if (bus.m_write) begin
                    mem[bus.m_address[ADDR_W-1:2]] <= bus.m_writedata;
                    wr_addr_q.push_back(bus.m_address);
                    wr_data_q.push_back(bus.m_writedata);
                    wr_cyc_q.push_back(cyc);
                end else begin
                    rd_cyc_q.push_back(cyc);
                    if (rd_lat <= 1) begin
                        bus.m_readdatavalid <= 1'b1;
                        bus.m_readdata      <= mem[bus.m_address[ADDR_W-1:2]];
                    end else begin
                        rd_cnt  <= rd_lat - 1;
                        rd_hold <= mem[bus.m_address[ADDR_W-1:2]];
                    end
                end
            end
        end else begin
            stall_left <= stall_cfg;
        end
        if (bus.m_read && bus.m_write) rw_both <= rw_both + 1;
        if (stall_prev && !(bus.m_read == prev_rd && bus.m_write == prev_wr &&
                             bus.m_address == prev_addr && (!prev_wr || bus.m_writedata == prev_data)))
            unstable <= unstable + 1;
        stall_prev <= bus.m_waitrequest;
        prev_rd    <= bus.m_read;
        prev_wr    <= bus.m_write;
        prev_addr  <= bus.m_address;
        prev_data  <= bus.m_writedata;
        if (done) done_pulses <= done_pulses + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        pl_idx  = idx[15:0];
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                         input logic [LEN_W-1:0] len, input logic [31:0] pat, output int a);
        check("ready_before_cmd", cmd_ready, 1);
        cmd_op      = op;
        cmd_src     = src;
        cmd_dst     = dst;
        cmd_len     = len;
        cmd_pattern = pat;
        cmd_valid   = 1'b1;
        a = cyc;
        tick();
        cmd_valid   = 1'b0;
    endtask

    task automatic close_op(input string name, input int a, input int exp_lat, input logic exp_err);
        int i;
        i = 0;
        while (done !== 1'b1 && i < 64) begin
            tick();
            i++;
        end
        if (done !== 1'b1) begin
            check({name, "_done_timeout"}, 0, 1);
        end else begin
            check({name, "_done_latency"}, 64'(cyc - a), 64'(exp_lat));
            check({name, "_error"}, error, exp_err);
            tick();
            check({name, "_done_one_cycle"}, done, 0);
            check({name, "_ready_after"}, cmd_ready, 1);
            check({name, "_busy_after"}, busy, 0);
        end
    endtask

    int a, wb, rb, rc, dp;

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_dst = '0;
        cmd_len = '0; cmd_pattern = '0; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        repeat (2) tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_result", result, 0);
        check("rst_m_read", bus.m_read, 0);
        check("rst_m_write", bus.m_write, 0);
        check("rst_m_address", bus.m_address, 0);
        check("rst_m_writedata", bus.m_writedata, 0);
        check("rst_byteenable", bus.m_byteenable, 4'hF);
        reset_n = 1'b1;
        tick();

        // FILL, no stalls: one write per cycle
        wb = wr_addr_q.size();
        issue(2'd1, '0, 18'h100, 16'd4, 32'hA5A5_0001, a);
        check("fill_busy", busy, 1);
        check("fill_ready_low", cmd_ready, 0);
        check("fill_first_write", bus.m_write, 1);
        check("fill_first_addr", bus.m_address, 18'h100);
        check("fill_first_data", bus.m_writedata, 32'hA5A5_0001);
        close_op("fill", a, 5, 1'b0);
        check("fill_nwrites", wr_addr_q.size() - wb, 4);
        for (int i = 0; i < 4; i++) begin
            check("fill_addr", wr_addr_q[wb+i], 18'h100 + 18'(4*i));
            check("fill_data", wr_data_q[wb+i], 32'hA5A5_0001);
            check("fill_cycle", wr_cyc_q[wb+i], a + 1 + i);
        end

        // COPY with two wait cycles on every request
        preload(0, 32'd1);
        preload(1, 32'd2);
        preload(2, 32'd3);
        stall_cfg = 2;
        wb = wr_addr_q.size();
        dp = done_pulses;
        issue(2'd0, 18'h0, 18'h40, 16'd3, 32'h0, a);
        close_op("copy_stall", a, 22, 1'b0);
        stall_cfg = 0;
        check("copy_stall_ndone", done_pulses - dp, 1);
        check("copy_stall_nwrites", wr_addr_q.size() - wb, 3);
        for (int i = 0; i < 3; i++) begin
            check("copy_stall_mem", mem[16+i], 32'(i + 1));
            check("copy_stall_addr", wr_addr_q[wb+i], 18'h40 + 18'(4*i));
        end

        // COPY zero wait: 3 cycles per word
        wb = wr_addr_q.size();
        rb = rd_cyc_q.size();
        issue(2'd0, 18'h4, 18'h60, 16'd2, 32'h0, a);
        close_op("copy", a, 7, 1'b0);
        check("copy_rd0_cycle", rd_cyc_q[rb], a + 1);
        check("copy_wr0_cycle", wr_cyc_q[wb], a + 3);
        check("copy_rd1_cycle", rd_cyc_q[rb+1], a + 4);
        check("copy_wr1_cycle", wr_cyc_q[wb+1], a + 6);
        check("copy_wr1_data", wr_data_q[wb+1], 32'd3);

        // CHECKSUM wraps modulo 2^32
        preload(18'h200 >> 2, 32'hFFFF_FFFF);
        preload((18'h200 >> 2) + 1, 32'h2);
        preload((18'h200 >> 2) + 2, 32'h10);
        wb = wr_addr_q.size();
        rb = rd_cyc_q.size();
        issue(2'd2, 18'h200, 18'h0, 16'd3, 32'h0, a);
        close_op("csum", a, 7, 1'b0);
        check("csum_result", result, 32'h0000_0011);
        check("csum_no_writes", wr_addr_q.size() - wb, 0);
        check("csum_rd2_cycle", rd_cyc_q[rb+2], a + 5);

        // Rejected commands: no bus activity
        rc = req_cycles;
        issue(2'd3, 18'h0, 18'h0, 16'd4, 32'h0, a);
        close_op("err_op3", a, 1, 1'b1);
        check("err_op3_nobus", req_cycles - rc, 0);
        rc = req_cycles;
        issue(2'd2, 18'h102, 18'h0, 16'd2, 32'h0, a);
        close_op("err_unaligned", a, 1, 1'b1);
        check("err_unaligned_nobus", req_cycles - rc, 0);

        // Zero length clears result
        rc = req_cycles;
        issue(2'd1, 18'h0, 18'h80, 16'd0, 32'h1234, a);
        close_op("zero_len", a, 1, 1'b0);
        check("zero_len_result", result, 0);
        check("zero_len_nobus", req_cycles - rc, 0);

        // Address wrap-around
        wb = wr_addr_q.size();
        issue(2'd1, 18'h0, 18'h3FFF8, 16'd3, 32'h5A5A_1234, a);
        close_op("wrap", a, 4, 1'b0);
        check("wrap_addr0", wr_addr_q[wb], 18'h3FFF8);
        check("wrap_addr1", wr_addr_q[wb+1], 18'h3FFFC);
        check("wrap_addr2", wr_addr_q[wb+2], 18'h00000);

        // Reset during RD_WAIT, late readdatavalid afterwards
        rd_lat = 2;
        wb = wr_addr_q.size();
        dp = done_pulses;
        issue(2'd0, 18'h0, 18'h80, 16'd1, 32'h0, a);
        check("rst_mid_read_req", bus.m_read, 1);
        tick();
        check("rst_mid_in_rd_wait", bus.m_read, 0);
        check("rst_mid_busy_before", busy, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rst_mid_m_read", bus.m_read, 0);
        check("rst_mid_m_write", bus.m_write, 0);
        check("rst_mid_ready", cmd_ready, 1);
        check("rst_mid_busy", busy, 0);
        repeat (3) tick();
        rd_lat = 1;
        check("rst_mid_no_write", wr_addr_q.size() - wb, 0);
        check("rst_mid_no_done", done_pulses - dp, 0);
        check("rst_mid_still_idle", cmd_ready, 1);

        wb = wr_addr_q.size();
        issue(2'd1, 18'h0, 18'h300, 16'd1, 32'h0000_0007, a);
        close_op("post_reset_fill", a, 2, 1'b0);
        check("post_reset_addr", wr_addr_q[wb], 18'h300);

        check("rw_never_both", rw_both, 0);
        check("stall_stable", unstable, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/onchip_mem_master.md
# onchip_mem_master

Command-driven Avalon-MM master that runs block operations against the firmware on-chip memory's s1/s2 slave port: word copy, pattern fill, and 32-bit additive checksum. It sits between a control agent (CPU-side register block or test sequencer) and the system interconnect. It issues byte-addressed, single-word, non-pipelined transfers. It honours `m_waitrequest` and `m_readdatavalid`, so it works with the memory's fixed one-cycle read latency and with fabric-inserted stalls.

## Interface
- `ADDR_W`, 18: byte-address width (51200 words × 4 B fits in 18 bits).
- `LEN_W`, 16: word-count width.
- `clk` in 1: sole clock.
- `reset_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: block idle, accepts a command.
- `cmd_op` in 2: 0 = COPY, 1 = FILL, 2 = CHECKSUM, 3 = reserved.
- `cmd_src` in ADDR_W: source byte address (COPY, CHECKSUM).
- `cmd_dst` in ADDR_W: destination byte address (COPY, FILL).
- `cmd_len` in LEN_W: number of 32-bit words.
- `cmd_pattern` in 32: FILL data.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: valid with `done`; command rejected.
- `result` out 32: checksum, valid from `done` until the next accept.
- `m_address` out ADDR_W: Avalon byte address.
- `m_read` out 1: Avalon read request.
- `m_write` out 1: Avalon write request.
- `m_writedata` out 32: Avalon write data.
- `m_byteenable` out 4: constant 4'hF.
- `m_waitrequest` in 1: slave stall.
- `m_readdata` in 32: read data.
- `m_readdatavalid` in 1: read data qualifier.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH.
- IDLE: `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, latch all `cmd_*` fields, clear the word counter and checksum accumulator, and set `busy`.
- Error check at accept:
  - An error is any of: `cmd_op`==3; any used address with bits [1:0]≠0; `cmd_len`==0 with op 3.
  - On error, go to FINISH with `error`=1. No bus cycle is issued.
- Zero length: `cmd_len`==0 with a valid op goes straight to FINISH with `error`=0 and `result`=0.
- COPY: RD_REQ at src → RD_WAIT → WR_REQ at dst with the captured `m_readdata` → repeat.
- FILL: WR_REQ only. `m_writedata`=pattern, held continuously across words.
- CHECKSUM: RD_REQ → RD_WAIT → repeat. `acc = acc + m_readdata`, modulo 2^32. No writes.
- RD_REQ/WR_REQ: the request is held, with address and data stable, while `m_waitrequest`=1. The transfer is accepted in the cycle the request is high and `m_waitrequest`=0.
- RD_WAIT: `m_read`=0. Waits indefinitely for `m_readdatavalid`; data is captured in that cycle.
- Addressing: after each word, src/dst advance by 4, modulo 2^ADDR_W (wrap to 0, no error).
- Completion: after word `cmd_len`, go to FINISH.
  - FINISH pulses `done` for one cycle, updates `result`, clears `busy`, and returns to IDLE.
- `m_read` and `m_write` are never both high. `cmd_*` inputs are ignored while busy.
- `m_readdatavalid` outside RD_WAIT is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - `cmd_ready`=1, all other outputs 0. `busy`, `done`, `error` all 0.
  - `result`=0, `m_address`=0, `m_writedata`=0.
  - `m_byteenable`=4'hF at all times.
- Reset mid-operation: on the cycle after `reset_n` is sampled low, `m_read` and `m_write` are 0 and the state is IDLE. The outstanding transfer is abandoned and a late `m_readdatavalid` is ignored.
- Accept to first request: accept at cycle A, request visible at A+1.
- Throughput with zero wait and read latency 1:
  - COPY: 3 cycles/word. Read accepted at N, valid at N+1, write at N+2, next read at N+3.
  - CHECKSUM: 2 cycles/word.
  - FILL: 1 cycle/word.
- `done` asserts the cycle after the last write accept (COPY/FILL) or the last `m_readdatavalid` (CHECKSUM).
  - For errors and zero length, `done` asserts at A+1.
- `cmd_ready` returns high the cycle after `done`.
- A back-to-back command is accepted at the earliest in that cycle.

## Test plan
- FILL dst=0x100, len=4, pattern=0xA5A5_0001, no stalls → writes at 0x100/104/108/10C on 4 consecutive cycles, then `done` one cycle after, `error`=0.
- COPY src=0x0 holding {1,2,3}, dst=0x40, len=3, with `m_waitrequest` high for 2 cycles on every request → 0x40..0x48 read back {1,2,3}; requests stay stable while stalled; `done` once.
- CHECKSUM src=0x200 over {0xFFFF_FFFF, 0x2, 0x10}, len=3 → `result`=0x0000_0011 (modulo wrap); no `m_write` activity.
- Error cases → `done` and `error` at A+1, zero bus activity:
  - `cmd_op`=3.
  - src=0x102.
- Wrap-around: FILL dst=0x3FFF8, len=3 (ADDR_W=18) → writes at 0x3FFF8, 0x3FFFC, 0x00000.
- Reset: `reset_n` low in the middle of a COPY RD_WAIT, then `m_readdatavalid` one cycle later → next cycle `m_read`/`m_write`=0, `cmd_ready`=1, `busy`=0, no write issued.
